// File: rtl/spram_arb_pkg.sv
// ============================================================================
// Module      : spram_arb_pkg
// Description : Shared types and constants for the SPRAM sequencer/arbiter.
//               Defines the two-state sequencer encoding and the port count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spram_arb_pkg;

    // Number of requester ports sharing the single SRAM port.
    localparam int NPORT = 2;

    // INIT sweeps the array with zeros; RUN serves requesters forever.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/spram_rsp_slot.sv
// ============================================================================
// Module      : spram_rsp_slot
// Description : Per-port response slot. Raises valid the cycle after a grant,
//               passes sram_q straight through in that first cycle (the only
//               cycle Q is valid), and latches it if the requester does not
//               accept immediately. Write acknowledgements carry zero data.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_load          - grant for this port in the current cycle
//               i_load_rd       - the granted access is a read
//               i_rsp_ready     - requester consumes the response
//               i_sram_q        - SRAM read data (valid one cycle after read)
//               o_rsp_valid     - response available
//               o_rsp_rdata     - response data (0 for write acks / idle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_rsp_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_load_rd,
    input  logic                  i_rsp_ready,
    input  logic [DATA_WIDTH-1:0] i_sram_q,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata
);

    logic                  r_valid_q, w_valid_d;
    logic                  r_fresh_q, w_fresh_d;   // first response cycle
    logic                  r_rd_q,    w_rd_d;
    logic [DATA_WIDTH-1:0] r_data_q,  w_data_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_fresh_d = r_fresh_q;
        w_rd_d    = r_rd_q;
        w_data_d  = r_data_q;

        if (r_valid_q && i_rsp_ready) begin
            w_valid_d = 1'b0;
            w_fresh_d = 1'b0;
        end else if (r_fresh_q) begin
            // Not taken in its first cycle: capture Q before it goes stale.
            w_fresh_d = 1'b0;
            w_data_d  = r_rd_q ? i_sram_q : '0;
        end

        // The arbiter only grants when the slot is empty or draining now.
        if (i_load) begin
            w_valid_d = 1'b1;
            w_fresh_d = 1'b1;
            w_rd_d    = i_load_rd;
            w_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_fresh_q <= 1'b0;
            r_rd_q    <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_fresh_q <= w_fresh_d;
            r_rd_q    <= w_rd_d;
            r_data_q  <= w_data_d;
        end
    end

    assign o_rsp_valid = r_valid_q;
    assign o_rsp_rdata = !r_valid_q              ? '0       :
                         (r_fresh_q && r_rd_q)   ? i_sram_q : r_data_q;

endmodule

`default_nettype wire

// File: rtl/spram_arbiter.sv
// ============================================================================
// Module      : spram_arbiter
// Description : Two-port round-robin arbiter and init sequencer in front of a
//               single-port SRAM (active-low CEN/WEN, one-cycle read).
//               Zero-fills the array after reset (INIT_EN=1), then grants at
//               most one access per cycle; responses return one cycle later
//               through a per-port response slot.
// Ports       : CLK/RST                   - clock, async active-high reset
//               init_done                 - high once RUN is entered
//               pN_req_*                  - port N request channel (N=0,1)
//               pN_rsp_*                  - port N response channel
//               sram_cen/wen/a/d, sram_q  - SRAM macro interface
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    parameter  int INIT_EN    = 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  init_done,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_wr,
    input  logic [AW-1:0]         p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_wr,
    input  logic [AW-1:0]         p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [AW-1:0]         sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);
    localparam arb_state_e    C_RST_STATE = (INIT_EN != 0) ? INIT : RUN;

    arb_state_e      r_state_q, w_state_d;
    logic [AW-1:0]   r_init_cnt_q, w_init_cnt_d;
    logic            r_last_grant_q, w_last_grant_d;

    logic [NPORT-1:0]      w_req_valid, w_req_wr, w_rsp_ready, w_rsp_valid;
    logic [NPORT-1:0]      w_elig, w_grant;
    logic [AW-1:0]         w_req_addr  [NPORT];
    logic [DATA_WIDTH-1:0] w_req_wdata [NPORT];
    logic [DATA_WIDTH-1:0] w_rsp_rdata [NPORT];
    logic                  w_win;

    assign w_req_valid    = {p1_req_valid, p0_req_valid};
    assign w_req_wr       = {p1_req_wr,    p0_req_wr};
    assign w_rsp_ready    = {p1_rsp_ready, p0_rsp_ready};
    assign w_req_addr[0]  = p0_req_addr;
    assign w_req_addr[1]  = p1_req_addr;
    assign w_req_wdata[0] = p0_req_wdata;
    assign w_req_wdata[1] = p1_req_wdata;

    // A port may issue when its slot is empty or is being drained this cycle.
    assign w_elig = w_req_valid & (~w_rsp_valid | w_rsp_ready);

    always_comb begin
        w_state_d      = r_state_q;
        w_init_cnt_d   = r_init_cnt_q;
        w_last_grant_d = r_last_grant_q;
        w_grant        = '0;
        w_win          = 1'b0;
        sram_cen       = 1'b1;
        sram_wen       = 1'b1;
        sram_a         = '0;
        sram_d         = '0;

        if (!RST) begin
            if (r_state_q == INIT) begin
                sram_cen     = 1'b0;
                sram_wen     = 1'b0;
                sram_a       = r_init_cnt_q;
                w_init_cnt_d = r_init_cnt_q + AW'(1);
                if (r_init_cnt_q == C_LAST_ADDR) begin
                    w_state_d    = RUN;
                    w_init_cnt_d = '0;
                end
            end else if (|w_elig) begin
                // On conflict the port that did not win last time goes.
                if (&w_elig) w_win = ~r_last_grant_q;
                else         w_win = w_elig[1];
                w_grant[w_win] = 1'b1;
                w_last_grant_d = w_win;
                sram_cen       = 1'b0;
                sram_wen       = ~w_req_wr[w_win];
                sram_a         = w_req_addr[w_win];
                sram_d         = w_req_wdata[w_win];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q      <= C_RST_STATE;
            r_init_cnt_q   <= '0;
            r_last_grant_q <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_init_cnt_q   <= w_init_cnt_d;
            r_last_grant_q <= w_last_grant_d;
        end
    end

    // Gated by RST so it reads low during reset even when starting in RUN.
    assign init_done = (r_state_q == RUN) && !RST;

    generate
        for (genvar n = 0; n < NPORT; n++) begin : g_slot
            spram_rsp_slot #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk         (CLK),
                .rst         (RST),
                .i_load      (w_grant[n]),
                .i_load_rd   (~w_req_wr[n]),
                .i_rsp_ready (w_rsp_ready[n]),
                .i_sram_q    (sram_q),
                .o_rsp_valid (w_rsp_valid[n]),
                .o_rsp_rdata (w_rsp_rdata[n])
            );
        end
    endgenerate

    assign p0_req_ready = w_grant[0];
    assign p1_req_ready = w_grant[1];
    assign p0_rsp_valid = w_rsp_valid[0];
    assign p1_rsp_valid = w_rsp_valid[1];
    assign p0_rsp_rdata = w_rsp_rdata[0];
    assign p1_rsp_rdata = w_rsp_rdata[1];

endmodule

`default_nettype wire

// File: tb/tb_spram_arbiter.sv
// ============================================================================
// Module      : tb_spram_arbiter
// Description : Self-checking bench for spram_arbiter with a behavioural
//               SPRAM (random Q on non-read cycles). Inputs change on the
//               falling edge; outputs are compared 1 time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spram_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          init_done;
    logic          p0_req_valid, p0_req_ready, p0_req_wr, p0_rsp_valid, p0_rsp_ready;
    logic          p1_req_valid, p1_req_ready, p1_req_wr, p1_rsp_valid, p1_rsp_ready;
    logic [AW-1:0] p0_req_addr, p1_req_addr, sram_a;
    logic [DW-1:0] p0_req_wdata, p1_req_wdata, p0_rsp_rdata, p1_rsp_rdata;
    logic          sram_cen, sram_wen;
    logic [DW-1:0] sram_d, sram_q;

    always #5 CLK = ~CLK;

    spram_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_EN(1)) dut (
        .CLK(CLK), .RST(RST), .init_done(init_done),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_wr(p0_req_wr), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_wr(p1_req_wr), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    // Behavioural SPRAM: registered read, garbage on any non-read cycle.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (!sram_cen && !sram_wen) mem[sram_a] <= sram_d;
        if (!sram_cen && sram_wen)  sram_q <= mem[sram_a];
        else                        sram_q <= $urandom;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        p0_req_valid = 0; p0_req_wr = 0; p0_req_addr = '0; p0_req_wdata = '0; p0_rsp_ready = 1;
        p1_req_valid = 0; p1_req_wr = 0; p1_req_addr = '0; p1_req_wdata = '0; p1_rsp_ready = 1;
    endtask

    // Release reset on a falling edge and check the whole zero-fill sweep,
    // with both ports requesting to prove nothing is granted during INIT.
    task automatic release_and_sweep();
        @(negedge CLK);
        RST = 0;
        p0_req_valid = 1; p1_req_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 0) @(negedge CLK);
            #1;
            chk("init_cen", sram_cen, 0);
            chk("init_wen", sram_wen, 0);
            chk("init_addr", sram_a, i);
            chk("init_data", sram_d, 0);
            chk("init_done_low", init_done, 0);
            chk("init_rdy", {p1_req_ready, p0_req_ready}, 0);
            chk("init_rsp_valid", {p1_rsp_valid, p0_rsp_valid}, 0);
        end
        @(negedge CLK);
        p0_req_valid = 0; p1_req_valid = 0;
        #1;
        chk("init_done_high", init_done, 1);
        chk("run_idle_cen", sram_cen, 1);
    endtask

    typedef struct {
        logic v0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic rr0;
        logic v1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic rr1;
        logic e_rdy0, e_rdy1, e_cen, e_wen; logic [AW-1:0] e_a;
        logic e_rv0; logic [DW-1:0] e_rd0; logic e_rv1; logic [DW-1:0] e_rd1;
    } vec_t;

    vec_t vt [13];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom | 32'h1;
        set_idle();

        // Reset state, with requests present to confirm ready is gated.
        repeat (2) @(negedge CLK);
        p0_req_valid = 1; p1_req_valid = 1;
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_cen", sram_cen, 1);
        chk("rst_wen", sram_wen, 1);
        chk("rst_rdy", {p1_req_ready, p0_req_ready}, 0);
        chk("rst_rsp_valid", {p1_rsp_valid, p0_rsp_valid}, 0);
        chk("rst_rdata0", p0_rsp_rdata, 0);
        chk("rst_rdata1", p1_rsp_rdata, 0);
        set_idle();

        release_and_sweep();

        //       v0 w0 a0 d0           rr0 v1 w1 a1 d1         rr1 rdy0 rdy1 cen wen a  rv0 rd0          rv1 rd1
        vt[0]  = '{1, 1, 3, 32'hDEADBEEF, 1, 0, 0, 0, 0,         1,  1, 0, 0, 0, 3,  0, 0,            0, 0};
        vt[1]  = '{1, 0, 3, 0,            1, 0, 0, 0, 0,         1,  1, 0, 0, 1, 3,  1, 0,            0, 0};
        vt[2]  = '{1, 0, 5, 0,            1, 1, 1, 7, 32'h1234,  1,  0, 1, 0, 0, 7,  1, 32'hDEADBEEF, 0, 0};
        vt[3]  = '{1, 0, 5, 0,            1, 1, 0, 7, 0,         1,  1, 0, 0, 1, 5,  0, 0,            1, 0};
        vt[4]  = '{1, 0, 3, 0,            1, 1, 0, 7, 0,         1,  0, 1, 0, 1, 7,  1, 0,            0, 0};
        vt[5]  = '{1, 0, 3, 0,            1, 1, 0, 7, 0,         0,  1, 0, 0, 1, 3,  0, 0,            1, 32'h1234};
        vt[6]  = '{1, 0, 5, 0,            1, 1, 0, 7, 0,         0,  1, 0, 0, 1, 5,  1, 32'hDEADBEEF, 1, 32'h1234};
        vt[7]  = '{1, 0, 3, 0,            1, 1, 0, 7, 0,         0,  1, 0, 0, 1, 3,  1, 0,            1, 32'h1234};
        vt[8]  = '{0, 0, 0, 0,            1, 1, 0, 7, 0,         0,  0, 0, 1, 1, 0,  1, 32'hDEADBEEF, 1, 32'h1234};
        vt[9]  = '{0, 0, 0, 0,            1, 1, 0, 7, 0,         0,  0, 0, 1, 1, 0,  0, 0,            1, 32'h1234};
        vt[10] = '{0, 0, 0, 0,            1, 1, 0, 3, 0,         1,  0, 1, 0, 1, 3,  0, 0,            1, 32'h1234};
        vt[11] = '{0, 0, 0, 0,            1, 0, 0, 0, 0,         1,  0, 0, 1, 1, 0,  0, 0,            1, 32'hDEADBEEF};
        vt[12] = '{0, 0, 0, 0,            1, 0, 0, 0, 0,         1,  0, 0, 1, 1, 0,  0, 0,            0, 0};

        for (int v = 0; v < 13; v++) begin
            @(negedge CLK);
            p0_req_valid = vt[v].v0; p0_req_wr = vt[v].w0; p0_req_addr = vt[v].a0;
            p0_req_wdata = vt[v].d0; p0_rsp_ready = vt[v].rr0;
            p1_req_valid = vt[v].v1; p1_req_wr = vt[v].w1; p1_req_addr = vt[v].a1;
            p1_req_wdata = vt[v].d1; p1_rsp_ready = vt[v].rr1;
            #1;
            chk($sformatf("v%0d_rdy0", v), p0_req_ready, vt[v].e_rdy0);
            chk($sformatf("v%0d_rdy1", v), p1_req_ready, vt[v].e_rdy1);
            chk($sformatf("v%0d_cen", v), sram_cen, vt[v].e_cen);
            chk($sformatf("v%0d_rsp_valid0", v), p0_rsp_valid, vt[v].e_rv0);
            chk($sformatf("v%0d_rsp_valid1", v), p1_rsp_valid, vt[v].e_rv1);
            if (!vt[v].e_cen) begin
                chk($sformatf("v%0d_wen", v), sram_wen, vt[v].e_wen);
                chk($sformatf("v%0d_addr", v), sram_a, vt[v].e_a);
                if (!vt[v].e_wen)
                    chk($sformatf("v%0d_wdata", v), sram_d, vt[v].e_rdy0 ? vt[v].d0 : vt[v].d1);
            end else begin
                chk($sformatf("v%0d_wen_idle", v), sram_wen, 1);
            end
            if (vt[v].e_rv0) chk($sformatf("v%0d_rdata0", v), p0_rsp_rdata, vt[v].e_rd0);
            if (vt[v].e_rv1) chk($sformatf("v%0d_rdata1", v), p1_rsp_rdata, vt[v].e_rd1);
        end

        // Reset pulsed mid-INIT at init_cnt = 9: sweep restarts from 0.
        @(negedge CLK);
        set_idle();
        RST = 1;
        repeat (2) @(negedge CLK);
        RST = 0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge CLK);
            #1;
            chk("mid_init_addr", sram_a, i);
        end
        RST = 1;
        #1;
        chk("mid_init_rst_cen", sram_cen, 1);
        chk("mid_init_rst_done", init_done, 0);
        @(negedge CLK);
        release_and_sweep();

        // Fresh state: both ports read every cycle; grants alternate 0,1,...
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            p0_req_valid = (k < 6); p0_req_wr = 0; p0_req_addr = AW'(k);
            p1_req_valid = (k < 6); p1_req_wr = 0; p1_req_addr = AW'(8 + k);
            p0_rsp_ready = 1; p1_rsp_ready = 1;
            #1;
            chk("alt_rdy0", p0_req_ready, (k < 6) && (k % 2 == 0));
            chk("alt_rdy1", p1_req_ready, (k < 6) && (k % 2 == 1));
            chk("alt_rsp_valid0", p0_rsp_valid, (k > 0) && ((k - 1) % 2 == 0));
            chk("alt_rsp_valid1", p1_rsp_valid, (k > 0) && ((k - 1) % 2 == 1));
            if (p0_req_ready) chk("alt_addr0", sram_a, k);
            if (p1_req_ready) chk("alt_addr1", sram_a, 8 + k);
            if (p0_rsp_valid) chk("alt_rdata0", p0_rsp_rdata, 0);
            if (p1_rsp_valid) chk("alt_rdata1", p1_rsp_rdata, 0);
        end

        // Reset with a port 0 response pending: it must vanish for good.
        @(negedge CLK);
        set_idle();
        p0_req_valid = 1; p0_req_addr = 4'h3; p0_rsp_ready = 0;
        #1;
        chk("pend_grant", p0_req_ready, 1);
        @(negedge CLK);
        p0_req_valid = 0;
        #1;
        chk("pend_rsp_valid", p0_rsp_valid, 1);
        RST = 1;
        p0_req_valid = 1; p1_req_valid = 1;
        #1;
        chk("pend_rst_rsp_valid", p0_rsp_valid, 0);
        chk("pend_rst_rdata", p0_rsp_rdata, 0);
        chk("pend_rst_rdy", {p1_req_ready, p0_req_ready}, 0);
        chk("pend_rst_cen", sram_cen, 1);
        set_idle();
        p0_rsp_ready = 0;
        @(negedge CLK);
        release_and_sweep();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            chk("no_stale_rsp", {p1_rsp_valid, p0_rsp_valid}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
